vend_ctrl_fsm: RTL and testbench
================================

Name: vend_ctrl_fsm

Overview:
Clocked, parametrised vending controller. It accepts coded coins and accumulates credit. When credit reaches PRICE it dispenses one item. Remaining or cancelled credit is returned one unit per transfer to a change hopper over a valid/ready handshake. It replaces the combinational single-price coke vendor as the front-end controller between the coin acceptor and the dispense/hopper drivers.

Parameters:
PRICE, 3, item price in credit units (1..2^CREDIT_W-1)
VAL1, 1, credit value of coin code 2'b01
VAL2, 2, credit value of coin code 2'b10
VAL3, 5, credit value of coin code 2'b11
CREDIT_W, 4, credit register width; must satisfy 2^CREDIT_W-1 >= PRICE-1+max(VAL1,VAL2,VAL3)
TIMEOUT, 15, idle cycles in COLLECT before auto-refund; 0 disables the timeout
TO_W, 4, timeout counter width; must satisfy 2^TO_W-1 >= TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin  in  2  coin code sampled every edge; 00 = none, 01/10/11 = VAL1/VAL2/VAL3
cancel  in  1  refund request, level-sampled
chg_rdy  in  1  hopper ready for one change unit
dispense  out  1  one-cycle item release pulse
chg_vld  out  1  change unit offered
coin_rej  out  1  one-cycle pulse: coin refused, returned mechanically
busy  out  1  high in VEND or CHANGE
credit  out  CREDIT_W  current credit register

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE; credit=0; timeout counter=0; dispense, chg_vld, coin_rej and busy are all 0. Reset mid-VEND or mid-CHANGE abandons the operation with no dispense and no further change.
- Outputs are Moore, decoded from registered state:
  - dispense = (state==VEND)
  - chg_vld = (state==CHANGE)
  - busy = VEND|CHANGE
  - coin_rej is a registered flag.
- IDLE (credit=0):
  - coin!=0: credit<=val; next state VEND if val>=PRICE, else COLLECT.
  - cancel with no coin is ignored.
- COLLECT:
  - coin!=0 and cancel=0: credit<=credit+val, computed at CREDIT_W+1 bits so it never wraps. Next state VEND if the sum >= PRICE, else stay. Timeout counter clears.
  - cancel=1, with or without a coin: credit<=credit+val. Next state CHANGE, a full refund; cancel wins over vend in the same cycle.
  - No coin and no cancel: counter increments. When counter==TIMEOUT-1 (TIMEOUT>0), next state is CHANGE (refund) and the counter clears.
- VEND: lasts exactly one cycle (dispense=1). credit<=credit-PRICE. Next state CHANGE if the result is nonzero, else IDLE.
- CHANGE:
  - A unit transfers on any edge with chg_vld&&chg_rdy; credit decrements by 1.
  - When credit==1 and a transfer occurs, next state is IDLE with credit 0.
  - chg_rdy low: hold state and credit, with no timeout.
- coin!=0 in VEND or CHANGE: coin ignored for credit; coin_rej=1 in the following cycle only.
- cancel is ignored in VEND and CHANGE.
- Latency:
  - A coin sampled at edge k updates credit at edge k.
  - dispense is high during the cycle after edge k.
  - The first chg_vld appears the cycle after dispense.
  - Refund chg_vld appears the cycle after the cancel edge.
- Invariant: credit < PRICE in COLLECT; credit > 0 in CHANGE.

Test Plan:
1. Reset, coin=01 then coin=10 on consecutive edges -> credit 1, then 3; dispense high one cycle; credit 0; back to IDLE; chg_vld never asserted.
2. Single coin=11 (5) with chg_rdy=1 -> dispense one cycle, credit 2; chg_vld high 2 cycles (credit 2→1→0); IDLE; busy high for 3 cycles total.
3. coin=11 with chg_rdy held 0 for 4 cycles, then 1 -> chg_vld stays high and credit stays 2 during the stall; exactly 2 transfers after release.
4. coin=10, then cancel=1 with coin=01 on the same edge -> no dispense, refund 3 units via CHANGE, end credit 0.
5. coin=11, then coin=01 on the cycle after dispense -> coin_rej one-cycle pulse; credit path unaffected; total 2 change units returned. Separately, coin=01 then 15 idle cycles (TIMEOUT=15) -> auto-refund of 1 unit.
6. coin=11, assert rst_n=0 asynchronously mid-CHANGE (between clock edges) -> all outputs 0 and credit 0 immediately; after release the FSM resumes from IDLE.

Source files
------------

// File: rtl/vend_ctrl_fsm.sv
// Vending front-end: accumulates coin credit, dispenses at PRICE and
// returns leftover or cancelled credit one unit at a time to the hopper.
module vend_ctrl_fsm #(
  parameter int PRICE    = 3,
  parameter int VAL1     = 1,
  parameter int VAL2     = 2,
  parameter int VAL3     = 5,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 15,
  parameter int TO_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                chg_rdy,
  output logic                dispense,
  output logic                chg_vld,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT - 1);
  localparam bit                  TO_EN   = (TIMEOUT > 0);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                rej_q, rej_d;
  logic [CREDIT_W-1:0] val;
  logic [CREDIT_W:0]   sum;
  logic                coin_in;

  always_comb begin
    val = '0;
    case (coin)
      2'b01:   val = CREDIT_W'(VAL1);
      2'b10:   val = CREDIT_W'(VAL2);
      2'b11:   val = CREDIT_W'(VAL3);
      default: val = '0;
    endcase
  end

  assign coin_in = (coin != 2'b00);
  // One extra bit so the price compare cannot be fooled by a wrap.
  assign sum     = {1'b0, credit_q} + {1'b0, val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      rej_q    <= rej_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = '0;
    rej_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_in) begin
          credit_d = val;
          state_d  = ({1'b0, val} >= PRICE_X) ? S_VEND : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          // Refund wins even if this coin would have reached the price.
          credit_d = sum[CREDIT_W-1:0];
          state_d  = S_CHANGE;
        end else if (coin_in) begin
          credit_d = sum[CREDIT_W-1:0];
          if (sum >= PRICE_X) state_d = S_VEND;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VEND: begin
        rej_d    = coin_in;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q != PRICE_C) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        rej_d = coin_in;
        if (chg_rdy) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dispense = (state_q == S_VEND);
    chg_vld  = (state_q == S_CHANGE);
    busy     = (state_q == S_VEND) || (state_q == S_CHANGE);
    coin_rej = rej_q;
    credit   = credit_q;
  end

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Directed bench for vend_ctrl_fsm: vector table plus timeout and async-reset sequences.
module tb_vend_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [1:0] coin;
  logic       cancel;
  logic       chg_rdy;
  logic       dispense, chg_vld, coin_rej, busy;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;

  // exp = {dispense, chg_vld, coin_rej, busy, credit[3:0]} after the edge
  typedef struct {
    logic [1:0] coin;
    logic       cancel;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  vend_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .chg_rdy(chg_rdy),
    .dispense(dispense), .chg_vld(chg_vld), .coin_rej(coin_rej), .busy(busy),
    .credit(credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {dispense, chg_vld, coin_rej, busy, credit};
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got d/v/r/b/credit=%b want %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic cn, input logic r);
    coin = c; cancel = cn; chg_rdy = r;
  endtask

  function automatic void V(input logic [1:0] c, input logic cn, input logic r,
                            input logic d, input logic v, input logic rj,
                            input logic b, input logic [3:0] cr);
    vec_t t;
    t.coin = c; t.cancel = cn; t.rdy = r; t.exp = {d, v, rj, b, cr};
    vq.push_back(t);
  endfunction

  initial begin
    // two coins to exact price, cancel in IDLE ignored
    V(1,0,0, 0,0,0,0,1); V(2,0,0, 1,0,0,1,3); V(0,0,0, 0,0,0,0,0); V(0,1,0, 0,0,0,0,0);
    // single big coin, two change units
    V(3,0,1, 1,0,0,1,5); V(0,0,1, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1); V(0,0,1, 0,0,0,0,0);
    // hopper stall for 4 cycles, cancel ignored in CHANGE
    V(3,0,0, 1,0,0,1,5); V(0,0,0, 0,1,0,1,2); V(0,1,0, 0,1,0,1,2); V(0,0,0, 0,1,0,1,2);
    V(0,0,0, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1); V(0,0,1, 0,0,0,0,0);
    // cancel together with a coin: refund of 3, no dispense
    V(2,0,1, 0,0,0,0,2); V(1,1,1, 0,1,0,1,3); V(0,0,1, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1);
    V(0,0,1, 0,0,0,0,0);
    // coin during VEND is rejected
    V(3,0,1, 1,0,0,1,5); V(1,0,1, 0,1,1,1,2); V(0,0,1, 0,1,0,1,1); V(0,0,1, 0,0,0,0,0);
    // coin during a stalled CHANGE is rejected
    V(3,0,0, 1,0,0,1,5); V(0,0,0, 0,1,0,1,2); V(2,0,0, 0,1,1,1,2); V(0,0,1, 0,1,0,1,1);
    V(0,0,1, 0,0,0,0,0);
    // coin on the last change transfer: rejected, IDLE stays at 0
    V(3,0,1, 1,0,0,1,5); V(0,0,1, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1); V(1,0,1, 0,0,1,0,0);
    V(0,0,1, 0,0,0,0,0);
    // maximum credit 2+5=7 -> 4 change units
    V(2,0,0, 0,0,0,0,2); V(3,0,0, 1,0,0,1,7); V(0,0,1, 0,1,0,1,4); V(0,0,1, 0,1,0,1,3);
    V(0,0,1, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1); V(0,0,1, 0,0,0,0,0);
    // cancel without a coin
    V(1,0,0, 0,0,0,0,1); V(0,1,1, 0,1,0,1,1); V(0,0,1, 0,0,0,0,0);
    // three small coins reach price exactly
    V(1,0,0, 0,0,0,0,1); V(1,0,0, 0,0,0,0,2); V(1,0,0, 1,0,0,1,3); V(0,0,0, 0,0,0,0,0);
    // cancel beats vend on the edge that reaches price
    V(1,0,1, 0,0,0,0,1); V(2,1,1, 0,1,0,1,3); V(0,0,1, 0,1,0,1,2); V(0,0,1, 0,1,0,1,1);
    V(0,0,1, 0,0,0,0,0);

    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    #1;
    check("reset_t0", 0, 8'h00);
    step(); step();
    check("reset_hold", 0, 8'h00);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].coin, vq[i].cancel, vq[i].rdy);
      step();
      check("vec", i, vq[i].exp);
    end

    // auto-refund after 15 idle cycles
    drive(2'b01, 1'b0, 1'b1); step(); check("to_coin", 0, 8'h01);
    drive(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin step(); check("to_wait", i, 8'h01); end
    step(); check("to_fire", 0, 8'h51);
    step(); check("to_done", 0, 8'h00);

    // a coin clears the idle counter
    drive(2'b01, 1'b0, 1'b1); step(); check("toc_coin", 0, 8'h01);
    drive(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step();
    check("toc_mid", 0, 8'h01);
    drive(2'b01, 1'b0, 1'b1); step(); check("toc_coin2", 0, 8'h02);
    drive(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin step(); check("toc_wait", i, 8'h02); end
    step(); check("toc_fire", 0, 8'h52);
    step(); check("toc_drain", 0, 8'h51);
    step(); check("toc_done", 0, 8'h00);

    // asynchronous reset in the middle of a stalled CHANGE
    drive(2'b11, 1'b0, 1'b0); step(); check("ar_vend", 0, 8'h95);
    drive(2'b00, 1'b0, 1'b0); step(); check("ar_change", 0, 8'h52);
    #3 rst_n = 1'b0;
    #1 check("ar_async", 0, 8'h00);
    step(); check("ar_held", 0, 8'h00);
    #2 rst_n = 1'b1;
    drive(2'b01, 1'b0, 1'b1); step(); check("ar_resume", 0, 8'h01);
    drive(2'b00, 1'b1, 1'b1); step(); check("ar_cancel", 0, 8'h51);
    drive(2'b00, 1'b0, 1'b1); step(); check("ar_done", 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
